// File: rtl/rca_instr_encoder.sv
// rca_instr_encoder: turns one accepted RCA command into a burst of
// 1..MAX_BURST custom-opcode instruction words. Consecutive words differ
// only in rd, which steps by one (modulo 32) per consumed word.
module rca_instr_encoder #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_type,
    input  logic [1:0]                   cmd_sub,
    input  logic [4:0]                   cmd_rs1,
    input  logic [4:0]                   cmd_rs2,
    input  logic [4:0]                   cmd_rd,
    input  logic [$clog2(MAX_BURST)-1:0] cmd_count,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instruction,
    output logic                         cmd_error,
    output logic                         busy
);

    localparam int unsigned CNT_W     = $clog2(MAX_BURST);
    localparam logic [6:0]  RCA_OPC   = 7'b0101011;
    localparam logic [3:0]  LAST_TYPE = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         type_q, type_d;
    logic [1:0]         sub_q, sub_d;
    logic [4:0]         rs1_q, rs1_d;
    logic [4:0]         rs2_q, rs2_d;
    logic [4:0]         rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               instr_valid_q, instr_valid_d;
    logic [31:0]        instruction_q, instruction_d;
    logic               cmd_error_q, cmd_error_d;
    logic               accept_c;
    logic               handshake_c;

    // Build one RCA instruction word from its fields.
    function automatic logic [31:0] encode(
        input logic [3:0] op_type,
        input logic [1:0] sub,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd
    );
        encode = {3'b000, op_type, rs2, rs1, 1'b0, sub, rd, RCA_OPC};
    endfunction

    // Ready/busy are gated by rst so both read 0 while reset is held.
    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE) && !rst;
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;
    assign cmd_error   = cmd_error_q;

    assign accept_c    = cmd_valid && (state_q == IDLE);
    assign handshake_c = instr_valid_q && instr_ready;

    // Next-state, command capture and next output word.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        sub_d         = sub_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        count_d       = count_q;
        idx_d         = idx_q;
        instr_valid_d = instr_valid_q;
        instruction_d = instruction_q;
        cmd_error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    type_d  = cmd_type;
                    sub_d   = cmd_sub;
                    rs1_d   = cmd_rs1;
                    rs2_d   = cmd_rs2;
                    rd_d    = cmd_rd;
                    count_d = cmd_count;
                    idx_d   = '0;
                    if (cmd_type <= LAST_TYPE) begin
                        state_d       = EMIT;
                        instr_valid_d = 1'b1;
                        instruction_d = encode(cmd_type, cmd_sub, cmd_rs1, cmd_rs2, cmd_rd);
                    end else begin
                        state_d     = ERROR;
                        cmd_error_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake_c) begin
                    if (idx_q == count_q) begin
                        state_d       = IDLE;
                        instr_valid_d = 1'b0;
                        idx_d         = '0;
                    end else begin
                        idx_d         = idx_q + CNT_W'(1);
                        rd_d          = rd_q + 5'd1;
                        instruction_d = encode(type_q, sub_q, rs1_q, rs2_q, rd_q + 5'd1);
                    end
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
                idx_d         = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            type_q        <= '0;
            sub_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            cmd_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            sub_q         <= sub_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

endmodule
